// File: rtl/branch_predictor_pkg.sv
// Shared control definitions for the branch predictor: PHT counter states,
// execute-stage branch-class encodings and a prediction helper.
package branch_predictor_pkg;

    // Two-bit saturating counter states held in each PHT entry.
    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } pht_state_e;

    // Execute-stage branch class encodings; 2'b11 is unused and never updates.
    localparam logic [1:0] BR_OP_NON_BRANCH = 2'b00;
    localparam logic [1:0] BR_OP_JUMP       = 2'b01;
    localparam logic [1:0] BR_OP_BRANCH     = 2'b10;

    // A counter predicts taken whenever its MSB is set (WEAK_T or STRONG_T).
    function automatic logic predict_taken(input pht_state_e state);
        return state[1];
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter_2b.sv
// Next-state logic for one 2-bit saturating PHT counter.
module sat_counter_2b
    import branch_predictor_pkg::*;
(
    input  pht_state_e state_i,
    input  logic       taken_i,
    output pht_state_e state_o
);

    // Step one state toward the resolved direction, holding at either end.
    always_comb begin
        state_o = state_i;
        unique case (state_i)
            STRONG_NT: state_o = taken_i ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   state_o = taken_i ? WEAK_T   : STRONG_NT;
            WEAK_T:    state_o = taken_i ? STRONG_T : WEAK_NT;
            STRONG_T:  state_o = taken_i ? STRONG_T : WEAK_T;
            default:   state_o = state_i;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Gshare branch predictor: PC/global-history indexed table of 2-bit counters,
// combinational fetch prediction, execute-stage training and statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned INDEX_W = 6,
    parameter int unsigned GHR_W   = INDEX_W
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [31:0]        pc_f_i,
    output logic               pred_taken_f_o,
    output logic [INDEX_W-1:0] pht_idx_f_o,
    input  logic [1:0]         branch_op_e_i,
    input  logic [INDEX_W-1:0] pht_idx_e_i,
    input  logic               pred_taken_e_i,
    input  logic               pc_src_res_e_i,
    input  logic               stall_e_i,
    output logic               mispredict_e_o,
    output logic [31:0]        branch_cnt_o,
    output logic [31:0]        mispred_cnt_o
);

    localparam int unsigned PHT_DEPTH = 1 << INDEX_W;

    if (GHR_W != INDEX_W) begin : g_bad_ghr_w
        $error("branch_predictor: GHR_W must equal INDEX_W");
    end

    // Flop-based table so every entry can be reset in a single cycle.
    pht_state_e         pht_q [PHT_DEPTH];
    pht_state_e         pht_d [PHT_DEPTH];
    logic [GHR_W-1:0]   ghr_q;
    logic [GHR_W-1:0]   ghr_d;
    logic [31:0]        branch_cnt_q;
    logic [31:0]        branch_cnt_d;
    logic [31:0]        mispred_cnt_q;
    logic [31:0]        mispred_cnt_d;

    logic               update_en;
    logic               is_ctrl_op;
    pht_state_e         cnt_cur;
    pht_state_e         cnt_next;

    // PC bits outside the index field do not influence the prediction.
    logic               unused_pc_bits;
    assign unused_pc_bits = ^{pc_f_i[31:INDEX_W+2], pc_f_i[1:0]};

    // Fetch side: reads the registered table, so a same-cycle update is not bypassed.
    assign pht_idx_f_o    = pc_f_i[INDEX_W+1:2] ^ ghr_q;
    assign pred_taken_f_o = predict_taken(pht_q[pht_idx_f_o]);

    // Execute side.
    assign update_en      = (branch_op_e_i == BR_OP_BRANCH) && !stall_e_i;
    assign is_ctrl_op     = (branch_op_e_i == BR_OP_BRANCH) || (branch_op_e_i == BR_OP_JUMP);
    assign mispredict_e_o = is_ctrl_op && (pred_taken_e_i != pc_src_res_e_i);
    assign cnt_cur        = pht_q[pht_idx_e_i];

    sat_counter_2b u_sat_counter (
        .state_i (cnt_cur),
        .taken_i (pc_src_res_e_i),
        .state_o (cnt_next)
    );

    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

    // Train the addressed counter, shift history and bump statistics.
    always_comb begin
        pht_d         = pht_q;
        ghr_d         = ghr_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (update_en) begin
            pht_d[pht_idx_e_i] = cnt_next;
            ghr_d              = {ghr_q[GHR_W-2:0], pc_src_res_e_i};
            branch_cnt_d       = branch_cnt_q + 32'd1;
        end
        if (mispredict_e_o && !stall_e_i) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    // State registers; reset wins over any concurrent update.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < PHT_DEPTH; i++) begin
                pht_q[i[INDEX_W-1:0]] <= WEAK_NT;
            end
            ghr_q         <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            pht_q         <= pht_d;
            ghr_q         <= ghr_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor against a behavioural gshare model.
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    localparam int IW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   pc;
    logic          pred_f;
    logic [IW-1:0] idx_f;
    logic [1:0]    op;
    logic [IW-1:0] idx_e;
    logic          pred_e, res, stall;
    logic          mis;
    logic [31:0]   bcnt, mcnt;

    always #5 clk = ~clk;

    branch_predictor #(.INDEX_W(IW), .GHR_W(IW)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .pc_f_i         (pc),
        .pred_taken_f_o (pred_f),
        .pht_idx_f_o    (idx_f),
        .branch_op_e_i  (op),
        .pht_idx_e_i    (idx_e),
        .pred_taken_e_i (pred_e),
        .pc_src_res_e_i (res),
        .stall_e_i      (stall),
        .mispredict_e_o (mis),
        .branch_cnt_o   (bcnt),
        .mispred_cnt_o  (mcnt)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: counter values 0..3, history as an integer.
    int        m_pht [64];
    int        m_ghr;
    bit [31:0] m_bcnt, m_mcnt;

    function automatic void model_reset();
        foreach (m_pht[i]) m_pht[i] = 1;
        m_ghr  = 0;
        m_bcnt = 0;
        m_mcnt = 0;
    endfunction

    function automatic bit exp_mis();
        return (op == BR_OP_BRANCH || op == BR_OP_JUMP) && (pred_e != res);
    endfunction

    function automatic int exp_idx(input logic [31:0] p);
        return ((p >> 2) & 63) ^ m_ghr;
    endfunction

    function automatic bit exp_pred(input logic [31:0] p);
        return m_pht[exp_idx(p)] >= 2;
    endfunction

    function automatic logic [31:0] pc_for(input int idx);
        return 32'h1000_0000 | (((idx ^ m_ghr) & 63) << 2);
    endfunction

    function automatic void model_edge();
        int e;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (exp_mis() && !stall) m_mcnt = m_mcnt + 1;
            if (op == BR_OP_BRANCH && !stall) begin
                e = int'(idx_e);
                if (res) m_pht[e] = (m_pht[e] < 3) ? m_pht[e] + 1 : 3;
                else     m_pht[e] = (m_pht[e] > 0) ? m_pht[e] - 1 : 0;
                m_ghr  = ((m_ghr << 1) | int'(res)) & 63;
                m_bcnt = m_bcnt + 1;
            end
        end
    endfunction

    task automatic drive(input logic [1:0] o, input int ie, input logic pe,
                         input logic r, input logic s, input logic [31:0] p);
        @(negedge clk);
        op     = o;
        idx_e  = ie[IW-1:0];
        pred_e = pe;
        res    = r;
        stall  = s;
        pc     = p;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(BR_OP_NON_BRANCH, 0, 0, 0, 0, 32'h0);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(BR_OP_BRANCH, 5, 0, 1, 0, 32'h100);
        tick();
        rst_n = 1'b1;
        drive(BR_OP_NON_BRANCH, 0, 0, 0, 0, 32'h100);
        total++; if (pred_f !== 1'b0) begin bad++; $display("FAIL reset_pred: got %0b want 0", pred_f); end
        total++; if (idx_f !== 6'h00) begin bad++; $display("FAIL reset_idx: got %0h want 00", idx_f); end
        total++; if (bcnt !== 32'd0) begin bad++; $display("FAIL reset_bcnt: got %0d want 0", bcnt); end
        total++; if (mcnt !== 32'd0) begin bad++; $display("FAIL reset_mcnt: got %0d want 0", mcnt); end
    endtask

    task automatic test_saturation();
        bit seq [6] = '{1, 1, 1, 1, 0, 0};
        for (int k = 0; k < 6; k++) begin
            drive(BR_OP_BRANCH, 5, 1, seq[k], 0, pc_for(5));
            tick();
            drive(BR_OP_NON_BRANCH, 0, 0, 0, 0, pc_for(5));
            total++; if (idx_f !== 6'd5) begin bad++; $display("FAIL sat_idx%0d: got %0d want 5", k, idx_f); end
            total++; if (pred_f !== exp_pred(pc)) begin bad++; $display("FAIL sat_pred%0d: got %0b want %0b", k, pred_f, exp_pred(pc)); end
            total++; if (bcnt !== m_bcnt) begin bad++; $display("FAIL sat_bcnt%0d: got %0d want %0d", k, bcnt, m_bcnt); end
        end
    endtask

    task automatic test_mispredict();
        int ghr_before;
        drive(BR_OP_BRANCH, 9, 0, 1, 0, pc_for(9));
        total++; if (mis !== 1'b1) begin bad++; $display("FAIL mis_branch: got %0b want 1", mis); end
        tick();
        total++; if (mcnt !== m_mcnt) begin bad++; $display("FAIL mis_branch_cnt: got %0d want %0d", mcnt, m_mcnt); end
        ghr_before = m_ghr;
        drive(BR_OP_JUMP, 9, 0, 1, 0, 32'h0);
        total++; if (mis !== 1'b1) begin bad++; $display("FAIL mis_jump: got %0b want 1", mis); end
        tick();
        drive(BR_OP_NON_BRANCH, 0, 0, 0, 0, 32'h0);
        total++; if (idx_f !== ghr_before[IW-1:0]) begin bad++; $display("FAIL jump_ghr: got %0h want %0h", idx_f, ghr_before); end
        total++; if (mcnt !== m_mcnt) begin bad++; $display("FAIL mis_jump_cnt: got %0d want %0d", mcnt, m_mcnt); end
        total++; if (bcnt !== m_bcnt) begin bad++; $display("FAIL jump_bcnt: got %0d want %0d", bcnt, m_bcnt); end
        drive(BR_OP_NON_BRANCH, 0, 0, 0, 0, pc_for(9));
        total++; if (pred_f !== exp_pred(pc)) begin bad++; $display("FAIL jump_pht: got %0b want %0b", pred_f, exp_pred(pc)); end
        drive(2'b11, 9, 0, 1, 0, 32'h0);
        total++; if (mis !== 1'b0) begin bad++; $display("FAIL mis_unknown: got %0b want 0", mis); end
        tick();
        total++; if (bcnt !== m_bcnt) begin bad++; $display("FAIL unknown_bcnt: got %0d want %0d", bcnt, m_bcnt); end
        drive(BR_OP_JUMP, 9, 1, 0, 1, 32'h0);
        total++; if (mis !== 1'b1) begin bad++; $display("FAIL mis_stalled: got %0b want 1", mis); end
        tick();
        total++; if (mcnt !== m_mcnt) begin bad++; $display("FAIL mis_stalled_cnt: got %0d want %0d", mcnt, m_mcnt); end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 3; k++) begin
            drive(BR_OP_BRANCH, 20, 0, 1, 1, 32'h0);
            tick();
            total++; if (bcnt !== m_bcnt) begin bad++; $display("FAIL stall_bcnt%0d: got %0d want %0d", k, bcnt, m_bcnt); end
            total++; if (idx_f !== exp_idx(32'h0)) begin bad++; $display("FAIL stall_ghr%0d: got %0h want %0h", k, idx_f, exp_idx(32'h0)); end
        end
        drive(BR_OP_BRANCH, 20, 0, 1, 0, 32'h0);
        tick();
        drive(BR_OP_NON_BRANCH, 0, 0, 0, 0, 32'h0);
        total++; if (bcnt !== m_bcnt) begin bad++; $display("FAIL stall_rel_bcnt: got %0d want %0d", bcnt, m_bcnt); end
        total++; if (idx_f !== exp_idx(32'h0)) begin bad++; $display("FAIL stall_rel_ghr: got %0h want %0h", idx_f, exp_idx(32'h0)); end
        drive(BR_OP_NON_BRANCH, 0, 0, 0, 0, pc_for(20));
        total++; if (pred_f !== exp_pred(pc)) begin bad++; $display("FAIL stall_rel_pht: got %0b want %0b", pred_f, exp_pred(pc)); end
    endtask

    task automatic test_ghr_index();
        bit seq [3] = '{1, 0, 1};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(BR_OP_BRANCH, 30, 0, seq[k], 0, 32'h0);
            tick();
        end
        drive(BR_OP_NON_BRANCH, 0, 0, 0, 0, 32'h0);
        total++; if (idx_f !== 6'b000101) begin bad++; $display("FAIL ghr_value: got %0h want 05", idx_f); end
        drive(BR_OP_NON_BRANCH, 0, 0, 0, 0, 32'h14);
        total++; if (idx_f !== 6'h00) begin bad++; $display("FAIL ghr_xor_idx: got %0h want 00", idx_f); end
        total++; if (pred_f !== exp_pred(pc)) begin bad++; $display("FAIL ghr_xor_pred: got %0b want %0b", pred_f, exp_pred(pc)); end
    endtask

    task automatic test_collision_reset();
        do_reset();
        drive(BR_OP_BRANCH, 3, 0, 1, 0, pc_for(3));
        total++; if (idx_f !== 6'd3) begin bad++; $display("FAIL coll_idx: got %0d want 3", idx_f); end
        total++; if (pred_f !== 1'b0) begin bad++; $display("FAIL coll_old: got %0b want 0", pred_f); end
        tick();
        drive(BR_OP_NON_BRANCH, 0, 0, 0, 0, pc_for(3));
        total++; if (pred_f !== 1'b1) begin bad++; $display("FAIL coll_new: got %0b want 1", pred_f); end
        rst_n = 1'b0;
        drive(BR_OP_BRANCH, 3, 1, 1, 0, pc_for(3));
        tick();
        rst_n = 1'b1;
        drive(BR_OP_NON_BRANCH, 0, 0, 0, 0, 32'h0c);
        total++; if (pred_f !== 1'b0) begin bad++; $display("FAIL rstpri_pred: got %0b want 0", pred_f); end
        total++; if (bcnt !== 32'd0) begin bad++; $display("FAIL rstpri_bcnt: got %0d want 0", bcnt); end
        drive(BR_OP_BRANCH, 3, 0, 1, 0, 32'h0c);
        tick();
        drive(BR_OP_NON_BRANCH, 0, 0, 0, 0, pc_for(3));
        total++; if (pred_f !== 1'b1) begin bad++; $display("FAIL rstpri_weak: got %0b want 1", pred_f); end
    endtask

    task automatic test_random();
        int ie;
        for (int k = 0; k < 400; k++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            ie = $urandom_range(0, 7);
            drive(2'($urandom_range(0, 3)), ie, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0), ($urandom_range(0, 1) != 0) ? pc_for(ie) : $urandom);
            total++; if (idx_f !== exp_idx(pc)) begin bad++; $display("FAIL rnd_idx%0d: got %0h want %0h", k, idx_f, exp_idx(pc)); end
            total++; if (pred_f !== exp_pred(pc)) begin bad++; $display("FAIL rnd_pred%0d: got %0b want %0b", k, pred_f, exp_pred(pc)); end
            total++; if (mis !== exp_mis()) begin bad++; $display("FAIL rnd_mis%0d: got %0b want %0b", k, mis, exp_mis()); end
            tick();
            total++; if (bcnt !== m_bcnt) begin bad++; $display("FAIL rnd_bcnt%0d: got %0d want %0d", k, bcnt, m_bcnt); end
            total++; if (mcnt !== m_mcnt) begin bad++; $display("FAIL rnd_mcnt%0d: got %0d want %0d", k, mcnt, m_mcnt); end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        pc     = 32'h0;
        op     = BR_OP_NON_BRANCH;
        idx_e  = '0;
        pred_e = 1'b0;
        res    = 1'b0;
        stall  = 1'b0;
        model_reset();
        test_reset();
        test_saturation();
        test_mispredict();
        test_stall();
        test_ghr_index();
        test_collision_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
